// File: rtl/gpio_port.sv
// gpio_port: memory-mapped general-purpose I/O port for the minx bus.
// WIDTH pins with per-pin direction, output latch, synchronised input,
// edge-selectable interrupt flags (write-1-to-clear) and a level irq.
// Register window: BASE_ADDR+0 DIR, +1 DATA, +2 IRQ_EN, +3 IRQ_EDGE, +4 IRQ_FLAG;
// +5..+7 read 0 and ignore writes. data_out is 0 unless read-addressed, so it
// can be OR-combined into the shared read mux.
// Optional input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_port #(
   parameter int unsigned WIDTH           = 8,
   parameter logic [23:0] BASE_ADDR       = 24'h2060,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [23:0]      address_in,
   input  logic [7:0]       data_in,
   input  logic             bus_write,
   input  logic             bus_read,
   output logic [7:0]       data_out,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_oe,
   output logic             irq
);

   // Address decode: offset wraps for addresses below BASE_ADDR, so a single
   // range test on the high bits covers both sides of the window.
   logic [23:0]      offset;
   logic             in_window;
   logic [2:0]       reg_sel;
   logic [WIDTH-1:0] wdata;

   assign offset    = address_in - BASE_ADDR;
   assign in_window = (offset[23:3] == 21'd0);
   assign reg_sel   = offset[2:0];
   assign wdata     = data_in[WIDTH-1:0];

   logic wr_dir, wr_data, wr_en, wr_edge, wr_flag;

   assign wr_dir  = bus_write && in_window && (reg_sel == 3'd0);
   assign wr_data = bus_write && in_window && (reg_sel == 3'd1);
   assign wr_en   = bus_write && in_window && (reg_sel == 3'd2);
   assign wr_edge = bus_write && in_window && (reg_sel == 3'd3);
   assign wr_flag = bus_write && in_window && (reg_sel == 3'd4);

   logic [WIDTH-1:0] dir_q, latch_q, irq_en_q, irq_edge_q, flag_q, flag_d;
   logic [WIDTH-1:0] s1_q, s2_q, prev_q, filt;
   logic [WIDTH-1:0] rise, fall, edge_det, flag_set;

   // Software-visible configuration registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir_q      <= '0;
         latch_q    <= '0;
         irq_en_q   <= '0;
         irq_edge_q <= '0;
      end else begin
         if (wr_dir)  dir_q      <= wdata;
         if (wr_data) latch_q    <= wdata;
         if (wr_en)   irq_en_q   <= wdata;
         if (wr_edge) irq_edge_q <= wdata;
      end
   end

   // Two-flop synchroniser for the asynchronous pads; prev tracks filt
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q   <= '0;
         s2_q   <= '0;
         prev_q <= '0;
      end else begin
         s1_q   <= pin_in;
         s2_q   <= s1_q;
         prev_q <= filt;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0][CntW-1:0] cnt_q;
   logic [WIDTH-1:0]           filt_q;

   // Per-pin debounce: s2 must disagree with filt for DEBOUNCE_CYCLES cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_q <= '0;
         cnt_q  <= '0;
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (s2_q[i] != filt_q[i]) begin
               if (cnt_q[i] == CntMax) begin
                  filt_q[i] <= s2_q[i];
                  cnt_q[i]  <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   assign filt = filt_q;
`else
   assign filt = s2_q;
`endif

   assign rise     = filt & ~prev_q;
   assign fall     = ~filt & prev_q;
   assign edge_det = (irq_edge_q & rise) | (~irq_edge_q & fall);
   // Output pins never raise flags
   assign flag_set = edge_det & irq_en_q & ~dir_q;

   // Flag next state: W1C first, then set, so a same-cycle set wins
   always_comb begin
      flag_d = flag_q;
      if (wr_flag) flag_d = flag_d & ~wdata;
      flag_d = flag_d | flag_set;
   end

   // Interrupt flag register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flag_q <= '0;
      end else begin
         flag_q <= flag_d;
      end
   end

   // Combinational read mux, zero when not read-addressed
   always_comb begin
      logic [WIDTH-1:0] rdata;
      rdata = '0;
      case (reg_sel)
         3'd0:    rdata = dir_q;
         3'd1:    rdata = (dir_q & latch_q) | (~dir_q & filt);
         3'd2:    rdata = irq_en_q;
         3'd3:    rdata = irq_edge_q;
         3'd4:    rdata = flag_q;
         default: rdata = '0;
      endcase
      data_out = '0;
      if (bus_read && in_window) data_out = 8'(rdata);
   end

   assign pin_out = latch_q;
   assign pin_oe  = dir_q;
   assign irq     = |(flag_q & irq_en_q);

endmodule
